logic_gate_pipe: RTL

Parametrised, pipelined N-operand, W-bit bitwise logic unit for the gate-lab library: OR, AND, XOR and their inverses, selected per transaction.
- Optional reduction of the W-bit result to a single bit.
- Two register stages with valid/ready backpressure; sustains one transaction per cycle.
- Serves as the common registered gate block for the datapath labs.

---
 rtl/logic_gate_pkg.sv | 46 ++++
 rtl/logic_gate_slice.sv | 44 ++++
 rtl/logic_gate_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// ---------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for the gate-lab pipelined logic unit.
//   OP_W            width of the operation code
//   OP_OR..OP_XNOR  legal operation codes (6 and 7 are illegal)
//   base_e          base gate function underlying an op (OR, AND, XOR)
//   is_illegal_op   flags the unused op codes
//   op_base         base gate function of an op
//   op_inverted     op is the inverted form of its base function
// ---------------------------------------------------------------------------
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_OR   = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        BASE_OR  = 2'd0,
        BASE_AND = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op > OP_XNOR);
    endfunction

    function automatic base_e op_base(input logic [OP_W-1:0] op);
        base_e b;
        case (op)
            OP_AND, OP_NAND: b = BASE_AND;
            OP_XOR, OP_XNOR: b = BASE_XOR;
            default:         b = BASE_OR;
        endcase
        return b;
    endfunction

    function automatic logic op_inverted(input logic [OP_W-1:0] op);
        return (op == OP_NOR) || (op == OP_NAND) || (op == OP_XNOR);
    endfunction

endpackage

// File: rtl/logic_gate_slice.sv
// ---------------------------------------------------------------------------
// logic_gate_slice
// Generic single-entry valid/ready register slice.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload
// in_ready_o depends only on the held state and out_ready_i, so there is no
// combinational path from in_valid_i to in_ready_o. Payload is held stable
// while out_valid_o is high and the downstream has not accepted it.
// ---------------------------------------------------------------------------
module logic_gate_slice #(
    parameter int unsigned P = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [P-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [P-1:0] out_data_o
);

    logic         valid_q;
    logic [P-1:0] data_q;

    // Empty, or draining on this edge: either way a new entry can be taken.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// ---------------------------------------------------------------------------
// logic_gate_pipe
// Two-stage pipelined N-operand, W-bit bitwise logic unit (OR, AND, XOR,
// NOR, NAND, XNOR) with optional reduction of the result to one bit.
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake
//   in_data[N*W]                 operand k at bits [k*W +: W]
//   in_op[3], in_reduce          operation code and reduce request
//   out_valid/out_ready          output handshake
//   out_data[W], out_err         result and illegal-op flag
//   perf_xfers, perf_stalls      (only with LOGIC_GATE_PIPE_PERF_EN defined)
//                                output handshakes / stalled output cycles
// Stage 1 registers the folded bitwise result; stage 2 registers the final
// (optionally reduced) result. Both stages are logic_gate_slice instances.
// ---------------------------------------------------------------------------
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [OP_W-1:0] in_op,
    input  logic            in_reduce,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
`ifdef LOGIC_GATE_PIPE_PERF_EN
    output logic [31:0]     perf_xfers,
    output logic [31:0]     perf_stalls,
`endif
    output logic            out_err
);

    typedef struct packed {
        logic            err;
        logic            reduce;
        logic [OP_W-1:0] op;
        logic [W-1:0]    res;
    } s1_t;

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_valid;
    logic s2_ready;

    // -----------------------------------------------------------------------
    // Stage 1 combinational: fold the op across all N operands.
    // -----------------------------------------------------------------------
    logic [W-1:0] fold;

    always_comb begin
        fold = in_data[W-1:0];
        for (int unsigned k = 1; k < N; k++) begin
            case (op_base(in_op))
                BASE_AND: fold = fold & in_data[k*W +: W];
                BASE_XOR: fold = fold ^ in_data[k*W +: W];
                default:  fold = fold | in_data[k*W +: W];
            endcase
        end

        s1_d.err    = is_illegal_op(in_op);
        s1_d.reduce = in_reduce;
        s1_d.op     = in_op;
        if (is_illegal_op(in_op)) begin
            s1_d.res = '0;
        end else if (op_inverted(in_op)) begin
            s1_d.res = ~fold;
        end else begin
            s1_d.res = fold;
        end
    end

    logic_gate_slice #(
        .P($bits(s1_t))
    ) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (s1_d),
        .out_valid_o(s1_valid),
        .out_ready_i(s2_ready),
        .out_data_o (s1_q)
    );

    // -----------------------------------------------------------------------
    // Stage 2 combinational: optional reduction. The reduction is applied to
    // the already-inverted stage-1 result and then inverted again for the
    // inverted ops, so e.g. NOR reduces as !(|(~fold)).
    // -----------------------------------------------------------------------
    logic red_bit;

    always_comb begin
        case (op_base(s1_q.op))
            BASE_AND: red_bit = &s1_q.res;
            BASE_XOR: red_bit = ^s1_q.res;
            default:  red_bit = |s1_q.res;
        endcase
        if (op_inverted(s1_q.op)) begin
            red_bit = !red_bit;
        end

        s2_d.err  = s1_q.err;
        s2_d.data = '0;
        if (s1_q.err) begin
            s2_d.data = '0;
        end else if (s1_q.reduce) begin
            s2_d.data[0] = red_bit;
        end else begin
            s2_d.data = s1_q.res;
        end
    end

    logic_gate_slice #(
        .P($bits(s2_t))
    ) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (s1_valid),
        .in_ready_o (s2_ready),
        .in_data_i  (s2_d),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (s2_q)
    );

    assign out_data = s2_q.data;
    assign out_err  = s2_q.err;

`ifdef LOGIC_GATE_PIPE_PERF_EN
    // -----------------------------------------------------------------------
    // Performance counters, free-running and wrapping.
    // -----------------------------------------------------------------------
    logic [31:0] perf_xfers_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_xfers_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (out_valid && out_ready) begin
                perf_xfers_q <= perf_xfers_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_xfers  = perf_xfers_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
